mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
- Upstream stage of the 10-bit signed MAC unit. Buffers operand pairs (a,b) arriving over a ready/valid stream in a small FIFO.
- Issues one pair per cycle to the MAC as a, b and valid_in, for a programmed vector length.
- Signals completion once the MAC pipeline has absorbed the final pair. The MAC has no backpressure, so the feeder alone paces issue.

Parameters:
- DATA_W, 10: operand width; must match the MAC a/b width.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- LEN_W, 10: width of the vector-length input.
- MAC_LAT, 2: clock edges from a mac_valid beat to the MAC's registered result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream pair valid.
- s_ready  out  1  FIFO can accept; equals !full.
- s_a  in  DATA_W  signed operand a.
- s_b  in  DATA_W  signed operand b.
- start  in  1  single-cycle pulse that begins a vector.
- len  in  LEN_W  number of pairs in the vector; sampled on start.
- mac_a  out  DATA_W  drives MAC a.
- mac_b  out  DATA_W  drives MAC b.
- mac_valid  out  1  drives MAC valid_in.
- mac_last  out  1  high with the final mac_valid beat of a vector.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (async assert, release sync to clk):
  - FIFO emptied; state IDLE; counters 0.
  - mac_a, mac_b, mac_valid, mac_last, busy, done all 0.
- Push: occurs when s_valid && s_ready. A push while full is impossible because s_ready=0; data is not lost, upstream holds.
- FSM states (enum in package): IDLE, RUN, DRAIN.
- IDLE:
  - start with len!=0 latches len, clears issue counter, goes to RUN.
  - start with len==0 is ignored: no done, stays IDLE.
  - The FIFO keeps accepting pushes in IDLE; entries wait.
- RUN:
  - Each cycle the FIFO is non-empty, pop the head and register it onto mac_a/mac_b with mac_valid=1 at the same edge. Increment the count.
  - If the FIFO is empty, mac_valid=0 for that cycle (bubble); no timeout.
  - The beat with count==len-1 also sets mac_last=1. The FSM then moves to DRAIN at that edge, and no further pops occur.
- DRAIN:
  - Counts MAC_LAT edges.
  - done=1 for exactly the cycle after the MAC_LAT-th edge following the edge that drove the last beat; then IDLE.
  - busy drops together with done rising.
- Latency: with the FIFO empty in RUN, a pair pushed at edge N appears on mac_a/mac_b with mac_valid=1 after edge N+1.
- Throughput: 1 pair/cycle. Simultaneous push and pop are allowed when not full, including when empty in RUN (bypass through storage, 1-cycle latency). Occupancy is unchanged on a simultaneous push and pop.
- Pointers: wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.
- When mac_valid=0, mac_a/mac_b hold their last values.
- start while busy is ignored; len is not re-sampled.
- Data passes through unmodified; there is no arithmetic on operands.
- Reset mid-vector aborts immediately: FIFO contents are discarded and no done is produced.

Optional Feature:
- Macro: MAC_FEEDER_LEVEL_EN.
- Defined: adds an output port level [$clog2(DEPTH):0], the registered FIFO occupancy. Reset value 0; it updates on the same edge as push/pop.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mac_feeder_pkg holds:
  - the state enum {IDLE, RUN, DRAIN};
  - localparam DATA_W_DEF=10;
  - a typedef operand_pair_t as a packed struct {signed a, signed b}.
- One sub-module: mac_operand_fifo, a synchronous FIFO (DEPTH, width 2*DATA_W) with push/pop/full/empty and an optional count output.
- The FSM and output registers live in mac_operand_feeder.

Test Plan:
- Reset mid-RUN after 2 of len=4 beats: all outputs 0 immediately. s_ready=1 after release. No done. A new start works.
- Back-to-back vector, FIFO preloaded with pairs (3,-2),(5,7),(-1,-1),(4,4), then start with len=4:
  - mac_valid high for 4 consecutive cycles carrying the pairs in order;
  - mac_last only on (4,4);
  - done exactly MAC_LAT+1 cycles after the last beat;
  - a downstream MAC reads f=-6+35+1+16=46.
- Full and backpressure, DEPTH=8, IDLE: push 9 pairs. s_ready drops after the 8th push and the 9th is held. start with len=9 drains all 9 in order with no loss.
- Bubbles: start with len=3 while the FIFO is empty; push one pair every third cycle. mac_valid has gaps, 3 beats total, done once.
- len=0 start and start while busy: both ignored. done never pulses spuriously; the active vector completes with its original len.
- With MAC_FEEDER_LEVEL_EN defined: push 5 pairs, then a simultaneous push and pop. level reads 5 and stays 5; it returns to 0 after drain.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// Shared types for the MAC operand feeder: FSM state encoding and the operand pair layout.
// Optional occupancy output is enabled with the MAC_FEEDER_LEVEL_EN macro (see mac_operand_feeder).
package mac_feeder_pkg;

    localparam int DATA_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } feeder_state_e;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] a;
        logic signed [DATA_W_DEF-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous FIFO holding operand pairs; extra pointer bit separates full from empty.
// With MAC_FEEDER_LEVEL_EN defined it also exports a registered occupancy count.
module mac_operand_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
`ifdef MAC_FEEDER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] count_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + (AW+1)'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + (AW+1)'(1);
            end
        end
    end

`ifdef MAC_FEEDER_LEVEL_EN
    // Kept as its own register so the exported level is glitch-free and equals wr-rd.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_o <= '0;
        end else begin
            case ({doPush, doPop})
                2'b10:   count_o <= count_o + (AW+1)'(1);
                2'b01:   count_o <= count_o - (AW+1)'(1);
                default: count_o <= count_o;
            endcase
        end
    end
`endif

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers (a,b) pairs and issues one per cycle to the 10-bit MAC for a programmed length, then pulses done.
// Define MAC_FEEDER_LEVEL_EN to expose the FIFO occupancy on the 'level' output.
module mac_operand_feeder
    import mac_feeder_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 8,
    parameter int LEN_W   = 10,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid,
    output logic              mac_last,
    output logic              busy,
    output logic              done
`ifdef MAC_FEEDER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    feeder_state_e        state_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     issueCnt_q;
    logic [DRAIN_W-1:0]   drainCnt_q;
    logic [DATA_W-1:0]    macA_q;
    logic [DATA_W-1:0]    macB_q;
    logic                 macValid_q;
    logic                 macLast_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 push;
    logic                 pop;
    logic [2*DATA_W-1:0]  head;

    assign s_ready = !fifoFull;
    assign push    = s_valid && !fifoFull;
    assign pop     = (state_q == RUN) && !fifoEmpty;

    mac_operand_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({s_a, s_b}),
        .rdata_o (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
`ifdef MAC_FEEDER_LEVEL_EN
        ,
        .count_o (level)
`endif
    );

    // A beat is issued only when the FIFO has data; empty cycles in RUN become bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issueCnt_q <= '0;
            drainCnt_q <= '0;
            macA_q     <= '0;
            macB_q     <= '0;
            macValid_q <= 1'b0;
            macLast_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            macValid_q <= 1'b0;
            macLast_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_q      <= len;
                        issueCnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (pop) begin
                        macA_q     <= head[2*DATA_W-1:DATA_W];
                        macB_q     <= head[DATA_W-1:0];
                        macValid_q <= 1'b1;
                        issueCnt_q <= issueCnt_q + LEN_W'(1);
                        if (issueCnt_q == len_q - LEN_W'(1)) begin
                            macLast_q  <= 1'b1;
                            drainCnt_q <= '0;
                            state_q    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Wait out the MAC pipeline so done coincides with its result being settled.
                    if (drainCnt_q == DRAIN_W'(MAC_LAT)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        drainCnt_q <= drainCnt_q + DRAIN_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mac_a     = macA_q;
    assign mac_b     = macB_q;
    assign mac_valid = macValid_q;
    assign mac_last  = macLast_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed self-checking bench for mac_operand_feeder (DEPTH=8, MAC_LAT=2).
// Build with MAC_FEEDER_LEVEL_EN defined to include the occupancy test.
module tb_mac_operand_feeder;

    localparam int DW    = 10;
    localparam int DEPTH = 8;
    localparam int LW    = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sValid;
    logic                 sReady;
    logic signed [DW-1:0] sA;
    logic signed [DW-1:0] sB;
    logic                 start;
    logic [LW-1:0]        len;
    logic signed [DW-1:0] macA;
    logic signed [DW-1:0] macB;
    logic                 macValid;
    logic                 macLast;
    logic                 busy;
    logic                 done;
`ifdef MAC_FEEDER_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_operand_feeder #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .LEN_W   (LW),
        .MAC_LAT (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (sValid),
        .s_ready   (sReady),
        .s_a       (sA),
        .s_b       (sB),
        .start     (start),
        .len       (len),
        .mac_a     (macA),
        .mac_b     (macB),
        .mac_valid (macValid),
        .mac_last  (macLast),
        .busy      (busy),
        .done      (done)
`ifdef MAC_FEEDER_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushPair(input int a, input int b);
        sValid = 1'b1;
        sA = DW'(a);
        sB = DW'(b);
        step();
        sValid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({macValid, macLast, busy, done} !== 4'b0000 || macA !== '0 || macB !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got valid=%b last=%b busy=%b done=%b a=%0d b=%0d, want all 0",
                     macValid, macLast, busy, done, macA, macB);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        total++;
        if (sReady !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: got s_ready=%b busy=%b, want 1/0", sReady, busy);
        end
    endtask

    task automatic test_back_to_back();
        int expA [4] = '{3, 5, -1, 4};
        int expB [4] = '{-2, 7, -1, 4};
        int sum = 0;
        for (int i = 0; i < 4; i++) pushPair(expA[i], expB[i]);
        start = 1'b1;
        len = 10'd4;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || macValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_start: got busy=%b valid=%b, want 1/0", busy, macValid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (macValid !== 1'b1 || macA !== DW'(expA[i]) || macB !== DW'(expB[i]) || macLast !== (i == 3)) begin
                bad++;
                $display("[TB] FAIL b2b_beat%0d: got v=%b a=%0d b=%0d last=%b, want v=1 a=%0d b=%0d last=%b",
                         i, macValid, macA, macB, macLast, expA[i], expB[i], (i == 3));
            end
            sum += int'(macA) * int'(macB);
        end
        total++;
        if (sum !== 46) begin
            bad++;
            $display("[TB] FAIL b2b_sum: got %0d, want 46", sum);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            total++;
            if (done !== (k == 3) || busy !== (k < 3) || macValid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL b2b_drain%0d: got done=%b busy=%b valid=%b, want done=%b busy=%b valid=0",
                         k, done, busy, macValid, (k == 3), (k < 3));
            end
        end
    endtask

    task automatic test_full();
        int expA [9];
        int expB [9];
        int beats = 0;
        bit accept;
        for (int i = 0; i < 9; i++) begin
            expA[i] = i * 7 - 20;
            expB[i] = 30 - i * 5;
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sReady !== 1'b1) begin
                bad++;
                $display("[TB] FAIL full_ready%0d: got %b, want 1", i, sReady);
            end
            pushPair(expA[i], expB[i]);
        end
        sValid = 1'b1;
        sA = DW'(expA[8]);
        sB = DW'(expB[8]);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (sReady !== 1'b0) begin
                bad++;
                $display("[TB] FAIL full_hold%0d: got s_ready=%b, want 0", k, sReady);
            end
            step();
        end
        start = 1'b1;
        len = 10'd9;
        accept = sValid && sReady;
        step();
        start = 1'b0;
        if (accept) sValid = 1'b0;
        for (int c = 0; c < 40 && beats < 9; c++) begin
            accept = sValid && sReady;
            step();
            if (accept) sValid = 1'b0;
            if (macValid === 1'b1) begin
                total++;
                if (macA !== DW'(expA[beats]) || macB !== DW'(expB[beats]) || macLast !== (beats == 8)) begin
                    bad++;
                    $display("[TB] FAIL full_beat%0d: got a=%0d b=%0d last=%b, want a=%0d b=%0d last=%b",
                             beats, macA, macB, macLast, expA[beats], expB[beats], (beats == 8));
                end
                beats++;
            end
        end
        total++;
        if (beats !== 9) begin
            bad++;
            $display("[TB] FAIL full_count: got %0d beats, want 9", beats);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            total++;
            if (done !== (k == 3)) begin
                bad++;
                $display("[TB] FAIL full_done%0d: got %b, want %b", k, done, (k == 3));
            end
        end
    endtask

    task automatic test_bubbles();
        int expA [3] = '{-100, 200, 17};
        int expB [3] = '{9, -3, -511};
        int pushes = 0;
        int beats = 0;
        bit expValid;
        start = 1'b1;
        len = 10'd3;
        step();
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c % 3 == 0 && pushes < 3) begin
                sValid = 1'b1;
                sA = DW'(expA[pushes]);
                sB = DW'(expB[pushes]);
                pushes++;
            end else begin
                sValid = 1'b0;
            end
            step();
            expValid = (c >= 1) && ((c - 1) % 3 == 0) && ((c - 1) / 3 < 3);
            total++;
            if (macValid !== expValid || done !== (c == 10)) begin
                bad++;
                $display("[TB] FAIL bubble_cyc%0d: got valid=%b done=%b, want valid=%b done=%b",
                         c, macValid, done, expValid, (c == 10));
            end
            if (expValid && macValid === 1'b1) begin
                total++;
                if (macA !== DW'(expA[beats]) || macB !== DW'(expB[beats]) || macLast !== (beats == 2)) begin
                    bad++;
                    $display("[TB] FAIL bubble_beat%0d: got a=%0d b=%0d last=%b, want a=%0d b=%0d last=%b",
                             beats, macA, macB, macLast, expA[beats], expB[beats], (beats == 2));
                end
                beats++;
            end
        end
        sValid = 1'b0;
    endtask

    task automatic test_len0_busy();
        int expA [2] = '{11, -12};
        int expB [2] = '{13, 14};
        pushPair(expA[0], expB[0]);
        pushPair(expA[1], expB[1]);
        pushPair(1, 1);
        pushPair(2, 2);
        start = 1'b1;
        len = 10'd0;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (busy !== 1'b0 || macValid !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL len0_cyc%0d: got busy=%b valid=%b done=%b, want 0/0/0", k, busy, macValid, done);
            end
            step();
        end
        start = 1'b1;
        len = 10'd2;
        step();
        for (int k = 1; k <= 7; k++) begin
            start = (k == 1);
            len = 10'd5;
            step();
            total++;
            if (macValid !== (k <= 2) || macLast !== (k == 2) || done !== (k == 5)) begin
                bad++;
                $display("[TB] FAIL busy_start_cyc%0d: got valid=%b last=%b done=%b, want %b/%b/%b",
                         k, macValid, macLast, done, (k <= 2), (k == 2), (k == 5));
            end
            if (k <= 2) begin
                total++;
                if (macA !== DW'(expA[k-1]) || macB !== DW'(expB[k-1])) begin
                    bad++;
                    $display("[TB] FAIL busy_start_data%0d: got a=%0d b=%0d, want a=%0d b=%0d",
                             k, macA, macB, expA[k-1], expB[k-1]);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 4; i++) pushPair(i + 1, -i);
        start = 1'b1;
        len = 10'd4;
        step();
        start = 1'b0;
        step();
        step();
        total++;
        if (macValid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrun_before: got valid=%b busy=%b, want 1/1", macValid, busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({macValid, macLast, busy, done} !== 4'b0000 || macA !== '0 || macB !== '0 || sReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrun_reset: got valid=%b last=%b busy=%b done=%b a=%0d b=%0d rdy=%b, want zeros rdy=1",
                     macValid, macLast, busy, done, macA, macB, sReady);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (done !== 1'b0 || macValid !== 1'b0 || sReady !== 1'b1) begin
                bad++;
                $display("[TB] FAIL midrun_after%0d: got done=%b valid=%b rdy=%b, want 0/0/1", k, done, macValid, sReady);
            end
        end
        pushPair(50, -3);
        pushPair(7, 2);
        start = 1'b1;
        len = 10'd2;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            total++;
            if (macValid !== (k <= 2) || done !== (k == 5)) begin
                bad++;
                $display("[TB] FAIL restart_cyc%0d: got valid=%b done=%b, want %b/%b", k, macValid, done, (k <= 2), (k == 5));
            end
            if (k <= 2) begin
                total++;
                if (macA !== DW'((k == 1) ? 50 : 7) || macB !== DW'((k == 1) ? -3 : 2)) begin
                    bad++;
                    $display("[TB] FAIL restart_data%0d: got a=%0d b=%0d, want a=%0d b=%0d",
                             k, macA, macB, (k == 1) ? 50 : 7, (k == 1) ? -3 : 2);
                end
            end
        end
    endtask

`ifdef MAC_FEEDER_LEVEL_EN
    task automatic test_level();
        int seenDone = 0;
        for (int i = 0; i < 5; i++) pushPair(i + 3, i - 3);
        total++;
        if (level !== 4'd5) begin
            bad++;
            $display("[TB] FAIL level_five: got %0d, want 5", level);
        end
        start = 1'b1;
        len = 10'd6;
        step();
        start = 1'b0;
        pushPair(99, -99);
        total++;
        if (level !== 4'd5 || macValid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL level_pushpop: got level=%0d valid=%b, want 5/1", level, macValid);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (done === 1'b1) seenDone++;
        end
        total++;
        if (level !== 4'd0 || seenDone !== 1) begin
            bad++;
            $display("[TB] FAIL level_drain: got level=%0d dones=%0d, want 0/1", level, seenDone);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        sValid = 1'b0;
        sA     = '0;
        sB     = '0;
        start  = 1'b0;
        len    = '0;
        test_reset();
        test_back_to_back();
        test_full();
        test_bubbles();
        test_len0_busy();
        test_reset_mid_run();
`ifdef MAC_FEEDER_LEVEL_EN
        test_level();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
